// File: rtl/grad_stream_core.sv
// Streaming 3x3 gradient engine: two line buffers, Sobel/Prewitt gx/gy,
// saturated L1 magnitude and 4-way direction, self-flushing the last row.
module grad_stream_core #(
    parameter int IMG_W = 1024,
    parameter int IMG_H = 768,
    parameter int PIX_W = 8,
    parameter int MAG_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_sel,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [MAG_W-1:0] out_mag,
    output logic [1:0]       out_dir
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = $clog2(IMG_H + 2);
    localparam int FW = $clog2(IMG_W + 1);
    localparam int GW = PIX_W + 4;
    localparam int SW = GW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

    state_t          state_q;
    logic            in_ready_q;
    logic            op_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [FW-1:0]   fl_q;

    logic            fire, start, real_acc, acc, last_col, out_en, brd_c, sof_c, eol_c;
    logic [RW-1:0]   pos_row, row_d, crow;
    logic [CW-1:0]   pos_col, col_d, ccol, rd_addr;
    logic [PIX_W-1:0] acc_pix;

    // Accept bookkeeping; a FLUSH cycle is a dummy accept carrying pixel 0.
    always_comb begin
        fire     = in_valid & in_ready_q;
        start    = fire & in_sof;
        real_acc = fire & (in_sof | (state_q == S_ACTIVE));
        acc      = real_acc | (state_q == S_FLUSH);
        acc_pix  = real_acc ? in_pix : '0;
        pos_row  = start ? '0 : row_q;
        pos_col  = start ? '0 : col_q;
        last_col = (pos_col == CW'(IMG_W - 1));
        col_d    = last_col ? '0 : pos_col + CW'(1);
        row_d    = last_col ? pos_row + RW'(1) : pos_row;
        rd_addr  = acc ? col_d : col_q;
        out_en   = (pos_row > RW'(1)) || ((pos_row == RW'(1)) && (pos_col != '0));
        // Window centre trails the newest pixel by one line plus one pixel.
        crow     = (pos_col == '0) ? pos_row - RW'(2) : pos_row - RW'(1);
        ccol     = (pos_col == '0) ? CW'(IMG_W - 1) : pos_col - CW'(1);
        brd_c    = (crow == '0) || (crow == RW'(IMG_H - 1)) ||
                   (ccol == '0) || (ccol == CW'(IMG_W - 1));
        sof_c    = (crow == '0) && (ccol == '0);
        eol_c    = (ccol == CW'(IMG_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            op_q       <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            fl_q       <= '0;
        end else begin
            if (acc) begin
                row_q <= row_d;
                col_q <= col_d;
            end
            if (start) begin
                op_q <= op_sel;
            end
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (start) begin
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    in_ready_q <= 1'b1;
                    if (real_acc && !start && (pos_row == RW'(IMG_H - 1)) && last_col) begin
                        state_q    <= S_FLUSH;
                        in_ready_q <= 1'b0;
                        fl_q       <= '0;
                    end
                end
                S_FLUSH: begin
                    in_ready_q <= 1'b0;
                    if (fl_q == FW'(IMG_W)) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        fl_q       <= '0;
                    end else begin
                        fl_q <= fl_q + FW'(1);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // One word per column holds {row r-2, row r-1}; read is prefetched for the next accept.
    logic [2*PIX_W-1:0] lb_mem [IMG_W];
    logic [2*PIX_W-1:0] lb_rd_q;

    always_ff @(posedge clk) begin
        if (acc) begin
            lb_mem[pos_col] <= {lb_rd_q[PIX_W-1:0], acc_pix};
        end
        lb_rd_q <= lb_mem[rd_addr];
    end

    // Stage 1: window, p[r][c] with r=0 top and c=2 the newest column.
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] col_in [3];
    logic             v1_q, b1_q, s1_q, e1_q, op1_q;

    always_comb begin
        col_in[0] = lb_rd_q[2*PIX_W-1:PIX_W];
        col_in[1] = lb_rd_q[PIX_W-1:0];
        col_in[2] = acc_pix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            v1_q  <= 1'b0;
            b1_q  <= 1'b0;
            s1_q  <= 1'b0;
            e1_q  <= 1'b0;
            op1_q <= 1'b0;
        end else begin
            v1_q <= acc & out_en;
            if (acc) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                    win_q[r][2] <= col_in[r];
                end
                b1_q  <= brd_c;
                s1_q  <= sof_c;
                e1_q  <= eol_c;
                op1_q <= op_q;
            end
        end
    end

    // Stage 2: gx/gy; the centre-tap weight is 2 for Sobel, 1 for Prewitt.
    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({4'b0000, p});
    endfunction

    function automatic logic signed [GW-1:0] ctr(input logic [PIX_W-1:0] p, input logic prew);
        return prew ? ext(p) : (ext(p) <<< 1);
    endfunction

    logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
    logic                 v2_q, s2_q, e2_q;

    always_comb begin
        gx_c = ext(win_q[0][0]) + ctr(win_q[1][0], op1_q) + ext(win_q[2][0])
             - ext(win_q[0][2]) - ctr(win_q[1][2], op1_q) - ext(win_q[2][2]);
        gy_c = ext(win_q[0][0]) + ctr(win_q[0][1], op1_q) + ext(win_q[0][2])
             - ext(win_q[2][0]) - ctr(win_q[2][1], op1_q) - ext(win_q[2][2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_q <= '0;
            gy_q <= '0;
            v2_q <= 1'b0;
            s2_q <= 1'b0;
            e2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            s2_q <= s1_q;
            e2_q <= e1_q;
            gx_q <= b1_q ? '0 : gx_c;
            gy_q <= b1_q ? '0 : gy_c;
        end
    end

    // Stage 3: magnitude with saturation, direction quantised by 2:1 slope tests.
    logic [GW-1:0]    ax_c, ay_c;
    logic [SW-1:0]    sum_c;
    logic [MAG_W-1:0] mag_c;
    logic [1:0]       dir_c;

    always_comb begin
        ax_c  = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay_c  = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        sum_c = {1'b0, ax_c} + {1'b0, ay_c};
        if ({1'b0, ax_c} >= {ay_c, 1'b0}) begin
            dir_c = 2'b00;
        end else if ({ax_c, 1'b0} > {1'b0, ay_c}) begin
            dir_c = (gx_q[GW-1] == gy_q[GW-1]) ? 2'b01 : 2'b11;
        end else begin
            dir_c = 2'b10;
        end
    end

    generate
        if (MAG_W >= SW) begin : g_nosat
            assign mag_c = MAG_W'(sum_c);
        end else begin : g_sat
            assign mag_c = (|sum_c[SW-1:MAG_W]) ? '1 : sum_c[MAG_W-1:0];
        end
    endgenerate

    logic             out_valid_q, out_sof_q, out_eol_q;
    logic [MAG_W-1:0] out_mag_q;
    logic [1:0]       out_dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_mag_q   <= '0;
            out_dir_q   <= 2'b00;
        end else begin
            out_valid_q <= v2_q;
            out_sof_q   <= v2_q & s2_q;
            out_eol_q   <= v2_q & e2_q;
            out_mag_q   <= v2_q ? mag_c : '0;
            out_dir_q   <= v2_q ? dir_c : 2'b00;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_mag   = out_mag_q;
    assign out_dir   = out_dir_q;

endmodule
